// File: rtl/bcd_scan_sequencer_pkg.sv
// Shared types and constants for the BCD decoder scan sequencer.
package bcd_scan_pkg;

  localparam int NUM_DIGITS = 10;

  typedef logic [3:0] bcd_code_t;

  localparam bcd_code_t BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GAP   = 2'd2
  } scan_state_t;

endpackage

// File: rtl/bcd_scan_sequencer_if.sv
// Control/status bundle between the scan owner (master) and the sequencer (slave).
interface bcd_scan_sequencer_if #(
  parameter int DWELL_W = 8
) ();

  logic                               start;
  logic                               stop;
  logic                               mode_cont;
  logic [bcd_scan_pkg::NUM_DIGITS-1:0] digit_mask;
  logic [DWELL_W-1:0]                 dwell;
  bcd_scan_pkg::bcd_code_t            code;
  logic                               busy;
  logic                               frame_done;
  logic                               err;

  modport master (
    output start, stop, mode_cont, digit_mask, dwell,
    input  code, busy, frame_done, err
  );

  modport slave (
    input  start, stop, mode_cont, digit_mask, dwell,
    output code, busy, frame_done, err
  );

endinterface

// File: rtl/bcd_scan_sequencer_next_digit.sv
// Finds the next enabled digit above cur_idx and the lowest enabled digit.
// Purely combinational, no backpressure.
module bcd_next_digit
  import bcd_scan_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] mask,
  input  bcd_code_t             cur_idx,
  output bcd_code_t             next_idx,
  output logic                  found,
  output bcd_code_t             lowest_idx
);

  // Scan downwards so the last hit is the smallest qualifying index.
  always_comb begin
    next_idx   = '0;
    found      = 1'b0;
    lowest_idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_idx = 4'(i);
        if (4'(i) > cur_idx) begin
          next_idx = 4'(i);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_scan_sequencer.sv
// Steps a BCD decoder through enabled digits with per-digit dwell and blank gaps.
// All outputs registered; first digit one cycle after start; no backpressure.
module bcd_scan_sequencer
  import bcd_scan_pkg::*;
#(
  parameter int DWELL_W    = 8,
  parameter int GAP_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  bcd_scan_sequencer_if.slave bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int CNT_W = (DWELL_W > GAP_W) ? DWELL_W : GAP_W;
  localparam logic [CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  scan_state_t             state;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [DWELL_W-1:0]      dwell_m1_q;
  logic [DWELL_W-1:0]      dwell_in_m1;
  logic [CNT_W-1:0]        cnt;
  bcd_code_t               cur_idx;
  bcd_code_t               code_q;
  logic                    busy_q;
  logic                    frame_done_q;
  logic                    err_q;

  logic [NUM_DIGITS-1:0]   mask_sel;
  bcd_code_t               nd_next;
  logic                    nd_found;
  bcd_code_t               nd_lowest;
  logic                    step_now;

  // While idle the lowest-index lookup serves the incoming start mask.
  assign mask_sel    = (state == ST_IDLE) ? bus.digit_mask : mask_q;
  assign dwell_in_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

  assign step_now = (cnt == '0) &&
                    ((state == ST_GAP) ||
                     ((state == ST_DWELL) && (GAP_CYCLES == 0)));

  bcd_next_digit u_next_digit (
    .mask       (mask_sel),
    .cur_idx    (cur_idx),
    .next_idx   (nd_next),
    .found      (nd_found),
    .lowest_idx (nd_lowest)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      mask_q       <= '0;
      dwell_m1_q   <= '0;
      cnt          <= '0;
      cur_idx      <= '0;
      code_q       <= BLANK_CODE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      if (bus.stop) begin
        state  <= ST_IDLE;
        code_q <= BLANK_CODE;
        busy_q <= 1'b0;
        cnt    <= '0;
      end else if (step_now) begin
        cnt <= CNT_W'(dwell_m1_q);
        if (nd_found) begin
          cur_idx <= nd_next;
          code_q  <= nd_next;
          state   <= ST_DWELL;
        end else begin
          frame_done_q <= 1'b1;
          if (bus.mode_cont) begin
            cur_idx <= nd_lowest;
            code_q  <= nd_lowest;
            state   <= ST_DWELL;
          end else begin
            state  <= ST_IDLE;
            code_q <= BLANK_CODE;
            busy_q <= 1'b0;
          end
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              if (|bus.digit_mask) begin
                mask_q     <= bus.digit_mask;
                dwell_m1_q <= dwell_in_m1;
                cnt        <= CNT_W'(dwell_in_m1);
                cur_idx    <= nd_lowest;
                code_q     <= nd_lowest;
                busy_q     <= 1'b1;
                state      <= ST_DWELL;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_DWELL: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state  <= ST_GAP;
              code_q <= BLANK_CODE;
              cnt    <= GAP_LOAD;
            end
          end
          ST_GAP: begin
            cnt <= cnt - CNT_W'(1);
          end
          default: begin
            state  <= ST_IDLE;
            code_q <= BLANK_CODE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.code       = code_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_bcd_scan_sequencer.sv
// Bench for bcd_scan_sequencer: directed scenarios plus randomized frames vs an arithmetic frame model.
module tb_bcd_scan_sequencer;
  import bcd_scan_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bcd_scan_sequencer_if #(.DWELL_W(8)) bus_g1 ();
  bcd_scan_sequencer_if #(.DWELL_W(8)) bus_g0 ();

  bcd_scan_sequencer #(.DWELL_W(8), .GAP_CYCLES(1)) dut_g1 (
    .clk (clk), .rst (rst), .bus (bus_g1.slave)
  );
  bcd_scan_sequencer #(.DWELL_W(8), .GAP_CYCLES(0)) dut_g0 (
    .clk (clk), .rst (rst), .bus (bus_g0.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic sp, input logic mc,
                       input logic [9:0] m, input logic [7:0] dw);
    if (sel == 1) begin
      bus_g1.start = st; bus_g1.stop = sp; bus_g1.mode_cont = mc;
      bus_g1.digit_mask = m; bus_g1.dwell = dw;
    end else begin
      bus_g0.start = st; bus_g0.stop = sp; bus_g0.mode_cont = mc;
      bus_g0.digit_mask = m; bus_g0.dwell = dw;
    end
  endtask

  task automatic sample(input int sel, output logic [3:0] c, output logic b,
                        output logic fd, output logic e);
    if (sel == 1) begin
      c = bus_g1.code; b = bus_g1.busy; fd = bus_g1.frame_done; e = bus_g1.err;
    end else begin
      c = bus_g0.code; b = bus_g0.busy; fd = bus_g0.frame_done; e = bus_g0.err;
    end
  endtask

  // Expected outputs t cycles after the start edge, from frame arithmetic.
  function automatic void model(input logic [9:0] m, input int dw, input int g, input bit cont,
                                input int t, output logic [3:0] c, output logic b,
                                output logic fd);
    int digs[$];
    int d, p, len, off;
    d = (dw == 0) ? 1 : dw;
    for (int i = 0; i < 10; i++) if (m[i]) digs.push_back(i);
    p   = d + g;
    len = digs.size() * p;
    off = t - 1;
    b   = 1'b1;
    fd  = 1'b0;
    if (cont) begin
      fd  = (off > 0) && (off % len == 0);
      off = off % len;
    end else if (off >= len) begin
      c  = 4'hF;
      b  = 1'b0;
      fd = (off == len);
      return;
    end
    c = ((off % p) < d) ? 4'(digs[off / p]) : 4'hF;
  endfunction

  task automatic run_seq(input int sel, input logic [9:0] m, input int dw, input bit cont,
                         input int ncycles, input int restart_at, input string tag);
    logic [3:0] c, ec;
    logic       b, fd, e, eb, efd;
    logic [9:0] cm;
    logic [7:0] cdw;
    cm  = m;
    cdw = 8'(dw);
    drive(sel, 1'b1, 1'b0, cont, cm, cdw);
    step();
    drive(sel, 1'b0, 1'b0, cont, cm, cdw);
    for (int t = 1; t <= ncycles; t++) begin
      model(m, dw, (sel == 1) ? 1 : 0, cont, t, ec, eb, efd);
      sample(sel, c, b, fd, e);
      chk($sformatf("%s code t=%0d", tag, t), 32'(c), 32'(ec));
      chk($sformatf("%s busy t=%0d", tag, t), 32'(b), 32'(eb));
      chk($sformatf("%s frame_done t=%0d", tag, t), 32'(fd), 32'(efd));
      chk($sformatf("%s err t=%0d", tag, t), 32'(e), 32'(0));
      if (t == restart_at) begin
        cm  = 10'($urandom_range(1, 1023));
        cdw = 8'($urandom_range(0, 7));
        drive(sel, 1'b1, 1'b0, cont, cm, cdw);
      end else begin
        drive(sel, 1'b0, 1'b0, cont, cm, cdw);
      end
      step();
    end
    drive(sel, 1'b0, 1'b1, cont, cm, cdw);
    step();
    drive(sel, 1'b0, 1'b0, 1'b0, cm, cdw);
    sample(sel, c, b, fd, e);
    chk($sformatf("%s post-stop code", tag), 32'(c), 32'hF);
    chk($sformatf("%s post-stop busy", tag), 32'(b), 32'(0));
    chk($sformatf("%s post-stop frame_done", tag), 32'(fd), 32'(0));
  endtask

  initial begin
    logic [3:0] c;
    logic       b, fd, e, reached;
    logic [9:0] m;
    int         dw, len, nc, ra;
    bit         cont;
    int         sel;

    drive(1, 1'b0, 1'b0, 1'b0, 10'h0, 8'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 10'h0, 8'h0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sample(s, c, b, fd, e);
      chk($sformatf("reset code dut%0d", s), 32'(c), 32'hF);
      chk($sformatf("reset busy dut%0d", s), 32'(b), 32'(0));
      chk($sformatf("reset frame_done dut%0d", s), 32'(fd), 32'(0));
      chk($sformatf("reset err dut%0d", s), 32'(e), 32'(0));
    end

    // Single-shot sweep with a mid-frame restart attempt that must be ignored.
    run_seq(1, 10'b10_0000_0101, 3, 1'b0, 16, 6, "sweep");
    // Continuous wrap, no gaps, dwell 0 treated as 1.
    run_seq(0, 10'h3FF, 0, 1'b1, 25, 0, "wrap");

    drive(1, 1'b1, 1'b0, 1'b0, 10'h0, 8'd3);
    step();
    drive(1, 1'b0, 1'b0, 1'b0, 10'h0, 8'd3);
    sample(1, c, b, fd, e);
    chk("zero-mask err", 32'(e), 32'(1));
    chk("zero-mask busy", 32'(b), 32'(0));
    chk("zero-mask code", 32'(c), 32'hF);
    step();
    sample(1, c, b, fd, e);
    chk("zero-mask err cleared", 32'(e), 32'(0));
    chk("zero-mask still idle", 32'(b), 32'(0));

    drive(1, 1'b1, 1'b0, 1'b0, 10'h3FF, 8'd2);
    step();
    drive(1, 1'b0, 1'b0, 1'b0, 10'h3FF, 8'd2);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      sample(1, c, b, fd, e);
      if (c == 4'd5) reached = 1'b1;
      else step();
    end
    chk("abort reach code 5", 32'(reached), 32'(1));
    drive(1, 1'b1, 1'b1, 1'b0, 10'h3FF, 8'd2);
    step();
    drive(1, 1'b0, 1'b0, 1'b0, 10'h3FF, 8'd2);
    sample(1, c, b, fd, e);
    chk("abort code", 32'(c), 32'hF);
    chk("abort busy", 32'(b), 32'(0));
    chk("abort frame_done", 32'(fd), 32'(0));
    step();
    sample(1, c, b, fd, e);
    chk("abort stays idle", 32'(b), 32'(0));
    chk("abort no late done", 32'(fd), 32'(0));

    drive(1, 1'b1, 1'b0, 1'b1, 10'h0F0, 8'd4);
    step();
    drive(1, 1'b0, 1'b0, 1'b1, 10'h0F0, 8'd4);
    step();
    step();
    sample(1, c, b, fd, e);
    chk("pre-rst code", 32'(c), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 10'h0, 8'd0);
    sample(1, c, b, fd, e);
    chk("mid-rst code", 32'(c), 32'hF);
    chk("mid-rst busy", 32'(b), 32'(0));
    chk("mid-rst frame_done", 32'(fd), 32'(0));

    for (int it = 0; it < 30; it++) begin
      sel  = int'($urandom_range(0, 1));
      m    = 10'($urandom_range(1, 1023));
      dw   = int'($urandom_range(0, 5));
      cont = bit'($urandom_range(0, 1));
      len  = $countones(m) * (((dw == 0) ? 1 : dw) + ((sel == 1) ? 1 : 0));
      nc   = cont ? (2 * len + 2) : (len + 3);
      ra   = (len > 1) ? int'($urandom_range(1, len - 1)) : 0;
      run_seq(sel, m, dw, cont, nc, ra, $sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
